axil_master_bridge: RTL
=======================

# axil_master_bridge

Command-driven AXI4-Lite master that issues single read or write transactions toward memory-mapped peripherals such as the timer wrapper, and returns each outcome on a response channel. It is the initiator end of the peripheral register bus: CPU-side or test-sequencer logic posts one command, and the bridge runs the full AXI4-Lite handshake. A response-wait watchdog reports a hung peripheral instead of stalling the system.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 or 64)
- TIMEOUT, 1024, max cycles waiting for B/R after address/data acceptance; 0 disables

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response produced by watchdog
- m_awvalid/m_awready, m_awaddr[ADDR_W], m_awprot[3]  AW channel (prot fixed 3'b000)
- m_wvalid/m_wready, m_wdata[DATA_W], m_wstrb[DATA_W/8]  W channel
- m_bvalid/m_bready, m_bresp[2]  B channel
- m_arvalid/m_arready, m_araddr[ADDR_W], m_arprot[3]  AR channel (prot 3'b000)
- m_rvalid/m_rready, m_rdata[DATA_W], m_rresp[2]  R channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- cmd_ready = (state==IDLE) && !stale_b && !stale_r. Command fields latched on handshake.
- IDLE -> WR_REQ (write) or RD_REQ (read).
- WR_REQ: m_awvalid and m_wvalid both asserted. Each drops independently on its own handshake via aw_done/w_done flags, in either order or simultaneously. When both are done -> WR_RESP.
- WR_RESP: m_bready=1. On the B handshake, latch bresp -> RSP.
- RD_REQ: m_arvalid=1 until the AR handshake -> RD_RESP.
- RD_RESP: m_rready=1. On the R handshake, latch rdata and rresp -> RSP.
- RSP: rsp_valid=1 with outputs stable until rsp_ready -> IDLE.
- All AXI valids and readies are registered. A valid is never withdrawn before its handshake, so request phases have no timeout.
- Watchdog: the counter clears on entry to WR_RESP/RD_RESP and increments each cycle there. When it reaches TIMEOUT without a handshake:
  - go to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0;
  - set stale_b or stale_r.
- Stale sink: while stale_b=1, m_bready=1 in every state. The next B handshake is discarded and clears stale_b. stale_r/m_rready behave the same way. New commands are blocked until all stale flags clear.
- A response arriving on the exact cycle the counter reaches TIMEOUT is a normal response; timeout is not flagged.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, all m_*valid=0, m_bready=0, m_rready=0, addresses/data 0, stale flags 0, state IDLE.
- Cycle 0 command accepted; cycle 1 m_awvalid/m_wvalid (or m_arvalid) high.
- With a zero-wait slave responding one cycle after acceptance, rsp_valid rises at cycle 3. cmd_ready returns the cycle after the rsp handshake.
- Throughput: one transaction outstanding; no pipelining.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously); the in-flight command and stale state are lost.

## Test plan
- Zero-wait slave, write addr 0x0000_0004, data 0xDEAD_BEEF, strb 4'hF -> AW/W valid at cycle 1, rsp_valid at cycle 3 with rsp_resp=0, rsp_rdata=0.
- Read 0x0000_0008, arready delayed 2 cycles, rvalid 3 cycles after that with rdata 0x1234_5678 -> m_arvalid held stable throughout; rsp_rdata=0x1234_5678, rsp_resp=0.
- W accepted 3 cycles before AW, then a case with AW and W accepted on the same cycle -> each valid drops on its own handshake; exactly one B is awaited; rsp_valid once.
- rsp_ready held low 5 cycles -> rsp_valid and rsp data stable; cmd_ready stays 0 until the rsp handshake.
- TIMEOUT=16, read with no rvalid:
  - rsp_valid after 16 cycles in RD_RESP with rsp_resp=2'b10, rsp_timeout=1;
  - a late rvalid (rdata 0xAAAA_AAAA) is consumed with no response;
  - cmd_ready stays 0 until then.
- rst pulled low while m_awvalid=1 -> m_awvalid=0 and cmd_ready=1 without a clock edge; the next write completes normally.

Source files
------------

// File: rtl/axil_master_bridge_if.sv
// Bundle of the bridge's command/response channels and its AXI4-Lite master bus.
// The bridge takes the master modport; the command source and the peripheral take the slave modport.
interface axil_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;

  logic              m_awvalid;
  logic              m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_wvalid;
  logic              m_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_bvalid;
  logic              m_bready;
  logic [1:0]        m_bresp;
  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arprot;
  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_awvalid, m_awaddr, m_awprot,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready,
    output m_arvalid, m_araddr, m_arprot,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rresp,
    output m_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_awvalid, m_awaddr, m_awprot,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready,
    input  m_arvalid, m_araddr, m_arprot,
    output m_arready,
    output m_rvalid, m_rdata, m_rresp,
    input  m_rready
  );
endinterface

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response back,
// with a response watchdog that drains late B/R beats from a hung peripheral.
module axil_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  axil_master_bridge_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t            r_state, w_state;
  logic              r_awvalid, w_awvalid;
  logic              r_wvalid, w_wvalid;
  logic              r_bready, w_bready;
  logic              r_arvalid, w_arvalid;
  logic              r_rready, w_rready;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [STRB_W-1:0] r_wstrb, w_wstrb;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic [1:0]        r_rsp_resp, w_rsp_resp;
  logic              r_rsp_timeout, w_rsp_timeout;
  logic              r_stale_b, w_stale_b;
  logic              r_stale_r, w_stale_r;
  logic [CNT_W-1:0]  r_cnt, w_cnt;

  logic w_cmd_ready, w_cmd_hs, w_b_hs, w_r_hs, w_expire;

  assign w_cmd_ready = (r_state == IDLE) && !r_stale_b && !r_stale_r;
  assign w_cmd_hs    = bus.cmd_valid && w_cmd_ready;
  assign w_b_hs      = bus.m_bvalid && r_bready;
  assign w_r_hs      = bus.m_rvalid && r_rready;
  assign w_expire    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state       = r_state;
    w_awvalid     = r_awvalid;
    w_wvalid      = r_wvalid;
    w_arvalid     = r_arvalid;
    w_addr        = r_addr;
    w_wdata       = r_wdata;
    w_wstrb       = r_wstrb;
    w_rsp_rdata   = r_rsp_rdata;
    w_rsp_resp    = r_rsp_resp;
    w_rsp_timeout = r_rsp_timeout;
    w_stale_b     = r_stale_b && !w_b_hs;
    w_stale_r     = r_stale_r && !w_r_hs;
    w_cnt         = r_cnt;

    case (r_state)
      IDLE: begin
        if (w_cmd_hs) begin
          w_addr  = bus.cmd_addr;
          w_wdata = bus.cmd_wdata;
          w_wstrb = bus.cmd_wstrb;
          if (bus.cmd_write) begin
            w_state   = WR_REQ;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
          end else begin
            w_state   = RD_REQ;
            w_arvalid = 1'b1;
          end
        end
      end
      WR_REQ: begin
        w_awvalid = r_awvalid && !bus.m_awready;
        w_wvalid  = r_wvalid && !bus.m_wready;
        if (!w_awvalid && !w_wvalid) begin
          w_state = WR_RESP;
          w_cnt   = '0;
        end
      end
      WR_RESP: begin
        w_cnt = r_cnt + CNT_W'(1);
        // A beat landing on the expiry cycle still wins over the watchdog.
        if (w_b_hs) begin
          w_state       = RSP;
          w_rsp_rdata   = '0;
          w_rsp_resp    = bus.m_bresp;
          w_rsp_timeout = 1'b0;
        end else if (w_expire) begin
          w_state       = RSP;
          w_rsp_rdata   = '0;
          w_rsp_resp    = 2'b10;
          w_rsp_timeout = 1'b1;
          w_stale_b     = 1'b1;
        end
      end
      RD_REQ: begin
        w_arvalid = r_arvalid && !bus.m_arready;
        if (!w_arvalid) begin
          w_state = RD_RESP;
          w_cnt   = '0;
        end
      end
      RD_RESP: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (w_r_hs) begin
          w_state       = RSP;
          w_rsp_rdata   = bus.m_rdata;
          w_rsp_resp    = bus.m_rresp;
          w_rsp_timeout = 1'b0;
        end else if (w_expire) begin
          w_state       = RSP;
          w_rsp_rdata   = '0;
          w_rsp_resp    = 2'b10;
          w_rsp_timeout = 1'b1;
          w_stale_r     = 1'b1;
        end
      end
      RSP: begin
        if (bus.rsp_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase

    // Readies stay up while a stale beat is owed so the late response is swallowed.
    w_bready = (w_state == WR_RESP) || w_stale_b;
    w_rready = (w_state == RD_RESP) || w_stale_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
      r_stale_b     <= 1'b0;
      r_stale_r     <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state;
      r_awvalid     <= w_awvalid;
      r_wvalid      <= w_wvalid;
      r_bready      <= w_bready;
      r_arvalid     <= w_arvalid;
      r_rready      <= w_rready;
      r_addr        <= w_addr;
      r_wdata       <= w_wdata;
      r_wstrb       <= w_wstrb;
      r_rsp_rdata   <= w_rsp_rdata;
      r_rsp_resp    <= w_rsp_resp;
      r_rsp_timeout <= w_rsp_timeout;
      r_stale_b     <= w_stale_b;
      r_stale_r     <= w_stale_r;
      r_cnt         <= w_cnt;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.rsp_valid   = (r_state == RSP);
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_resp    = r_rsp_resp;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.m_awvalid   = r_awvalid;
  assign bus.m_awaddr    = r_addr;
  assign bus.m_awprot    = '0;
  assign bus.m_wvalid    = r_wvalid;
  assign bus.m_wdata     = r_wdata;
  assign bus.m_wstrb     = r_wstrb;
  assign bus.m_bready    = r_bready;
  assign bus.m_arvalid   = r_arvalid;
  assign bus.m_araddr    = r_addr;
  assign bus.m_arprot    = '0;
  assign bus.m_rready    = r_rready;
endmodule
